// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshakes between an issuer and the ALU sequencer.
// master drives commands and consumes results; slave is the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_src_acc;
  logic             in_wr_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b,
    output in_src_acc, in_wr_acc,
    input  in_ready,
    input  out_valid, out_result,
    input  out_carry, out_zero,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  in_src_acc, in_wr_acc,
    output in_ready,
    output out_valid, out_result,
    output out_carry, out_zero,
    input  out_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for a 4-bit combinational ALU: command FIFO,
// registered operand drive, result capture and accumulator.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             src_acc;
    logic             wr_acc;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             wr_acc_q, wr_acc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovld_q, ovld_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  cmd_t head;
  cmd_t in_cmd;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = bus.in_valid && !full;
  assign head  = mem_q[rp_q];

  assign in_cmd = '{
    op:      bus.in_op,
    a:       bus.in_a,
    b:       bus.in_b,
    src_acc: bus.in_src_acc,
    wr_acc:  bus.in_wr_acc
  };

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    wr_acc_d = wr_acc_q;
    acc_d    = acc_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovld_d   = ovld_q;
    pop      = 1'b0;

    if (push) begin
      mem_d[wp_q] = in_cmd;
      wp_d        = wp_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          rp_d     = rp_q + 1'b1;
          alu_a_d  = head.src_acc ? acc_q : head.a;
          alu_b_d  = head.b;
          alu_op_d = head.op;
          wr_acc_d = head.wr_acc;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        carry_d = alu_carry;
        ovld_d  = 1'b1;
        if (wr_acc_q) acc_d = alu_result;
        state_d = WAIT;
      end
      WAIT: begin
        if (ovld_q && bus.out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      wr_acc_q <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      wr_acc_q <= wr_acc_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovld_q   <= ovld_d;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = ovld_q;
  assign bus.out_result = res_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = (res_q == '0);
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
  assign acc            = acc_q;
  assign busy           = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural
// 4-bit ALU closing the loop on the alu_* ports.
module tb_alu_cmd_sequencer;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] NOT = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] SHR = 3'b111;

  logic       clk;
  logic       rst;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic [3:0] acc;
  logic       busy;

  int checks;
  int errors;

  alu_cmd_sequencer_if #(.WIDTH(4)) bus ();

  alu_cmd_sequencer #(
    .WIDTH(4),
    .DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .acc        (acc),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; SUB carry is the borrow out.
  always_comb begin
    logic [4:0] t;
    t = '0;
    case (alu_op)
      ADD: t = {1'b0, alu_a} + {1'b0, alu_b};
      SUB: t = {1'b0, alu_a} - {1'b0, alu_b};
      AND: t = {1'b0, alu_a & alu_b};
      OR:  t = {1'b0, alu_a | alu_b};
      XOR: t = {1'b0, alu_a ^ alu_b};
      NOT: t = {1'b0, ~alu_a};
      SHL: t = {alu_a, 1'b0};
      SHR: t = {alu_a[0], 1'b0, alu_a[3:1]};
      default: t = '0;
    endcase
    alu_result = t[3:0];
    alu_carry  = t[4];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       src,
    input logic       wr
  );
    logic done;
    done = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_src_acc = src;
    bus.in_wr_acc  = wr;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got in_ready=0 want 1");
    end
  endtask

  task automatic get_result(
    output logic [3:0] r,
    output logic       c,
    output logic       z,
    output time        t
  );
    logic done;
    done = 1'b0;
    r = 'x;
    c = 1'bx;
    z = 1'bx;
    t = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.out_valid) begin
        r = bus.out_result;
        c = bus.out_carry;
        z = bus.out_zero;
        t = $time;
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL result_timeout got out_valid=0 want 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
    end
    checks++;
    if ({bus.out_result, bus.out_carry} !== 5'b0) begin
      errors++;
      $display("FAIL rst_result got %h/%b want 0/0",
               bus.out_result, bus.out_carry);
    end
    checks++;
    if (bus.out_zero !== 1'b1) begin
      errors++;
      $display("FAIL rst_zero got %b want 1", bus.out_zero);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 11'b0) begin
      errors++;
      $display("FAIL rst_alu got %h %h %h want 0 0 0",
               alu_a, alu_b, alu_op);
    end
    checks++;
    if ({acc, bus.in_ready, busy} !== 6'b0000_1_0) begin
      errors++;
      $display("FAIL rst_acc_rdy_busy got %h %b %b want 0 1 0",
               acc, bus.in_ready, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_latency();
    bus.out_ready = 1'b1;
    push(ADD, 4'b0101, 4'b0011, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_push got v=%b busy=%b want 0 1",
               bus.out_valid, busy);
    end
    tick();
    checks++;
    if ({alu_a, alu_b, alu_op} !== {4'b0101, 4'b0011, ADD}
        || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_issue got %h %h %h v=%b want 5 3 0 0",
               alu_a, alu_b, alu_op, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 4'b1000
        || bus.out_carry !== 1'b0 || bus.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL lat_result got v=%b r=%b c=%b z=%b want 1 1000 0 0",
               bus.out_valid, bus.out_result,
               bus.out_carry, bus.out_zero);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_done got v=%b busy=%b want 0 0",
               bus.out_valid, busy);
    end
  endtask

  task automatic test_add_carry();
    logic [3:0] r;
    logic       c;
    logic       z;
    time        t;
    push(ADD, 4'b1111, 4'b0001, 1'b0, 1'b1);
    get_result(r, c, z, t);
    checks++;
    if ({r, c, z} !== {4'b0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_carry got r=%b c=%b z=%b want 0000 1 1",
               r, c, z);
    end
    checks++;
    if (acc !== 4'b0000) begin
      errors++;
      $display("FAIL add_carry_acc got %b want 0000", acc);
    end
  endtask

  task automatic test_chain();
    logic [3:0] r;
    logic       c;
    logic       z;
    time        t;
    push(ADD, 4'b0010, 4'b0011, 1'b0, 1'b1);
    push(ADD, 4'b1111, 4'b0100, 1'b1, 1'b1);
    get_result(r, c, z, t);
    checks++;
    if (r !== 4'b0101 || c !== 1'b0) begin
      errors++;
      $display("FAIL chain_1 got %b/%b want 0101/0", r, c);
    end
    get_result(r, c, z, t);
    checks++;
    if (r !== 4'b1001 || c !== 1'b0) begin
      errors++;
      $display("FAIL chain_2 got %b/%b want 1001/0", r, c);
    end
    checks++;
    if (acc !== 4'b1001) begin
      errors++;
      $display("FAIL chain_acc got %b want 1001", acc);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    push(AND, 4'b1100, 4'b1010, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first got v=%b rdy=%b want 1 1",
               bus.out_valid, bus.in_ready);
    end
    push(OR,  4'b1100, 4'b1010, 1'b0, 1'b0);
    push(XOR, 4'b1100, 4'b1010, 1'b0, 1'b0);
    push(NOT, 4'b1100, 4'b1010, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_three got in_ready=%b want 1", bus.in_ready);
    end
    push(SUB, 4'b1100, 4'b1010, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got rdy=%b busy=%b want 0 1",
               bus.in_ready, busy);
    end
  endtask

  task automatic test_stall_hold();
    bus.in_valid = 1'b1;
    bus.in_op    = SHL;
    bus.in_a     = 4'b0001;
    bus.in_b     = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 4'b1000
          || bus.out_carry !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got v=%b r=%b c=%b rdy=%b want 1 1000 0 0",
                 i, bus.out_valid, bus.out_result,
                 bus.out_carry, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [3:0] exp_r [5];
    logic [3:0] r;
    logic       c;
    logic       z;
    time        t;
    exp_r[0] = 4'b1000;
    exp_r[1] = 4'b1110;
    exp_r[2] = 4'b0110;
    exp_r[3] = 4'b0011;
    exp_r[4] = 4'b0010;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_result(r, c, z, t);
      checks++;
      if (r !== exp_r[i] || c !== 1'b0) begin
        errors++;
        $display("FAIL drain_%0d got %b/%b want %b/0",
                 i, r, c, exp_r[i]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle got busy=%b v=%b want 0 0",
               busy, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r;
    logic       c;
    logic       z;
    time        t0;
    time        t1;
    time        t2;
    bus.out_ready = 1'b1;
    push(SHL, 4'b0101, 4'b0000, 1'b0, 1'b0);
    push(SHR, 4'b0011, 4'b0000, 1'b0, 1'b0);
    push(SUB, 4'b0011, 4'b0101, 1'b0, 1'b0);
    get_result(r, c, z, t0);
    checks++;
    if (r !== 4'b1010 || c !== 1'b0) begin
      errors++;
      $display("FAIL b2b_shl got %b/%b want 1010/0", r, c);
    end
    get_result(r, c, z, t1);
    checks++;
    if (r !== 4'b0001 || c !== 1'b1) begin
      errors++;
      $display("FAIL b2b_shr got %b/%b want 0001/1", r, c);
    end
    get_result(r, c, z, t2);
    checks++;
    if (r !== 4'b1110 || c !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sub got %b/%b want 1110/1", r, c);
    end
    checks++;
    if (t1 - t0 != 30 || t2 - t1 != 30) begin
      errors++;
      $display("FAIL b2b_rate got %0t %0t want 30 30",
               t1 - t0, t2 - t1);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    push(ADD, 4'b0001, 4'b0001, 1'b0, 1'b0);
    tick();
    tick();
    push(ADD, 4'b0111, 4'b0001, 1'b0, 1'b1);
    push(OR,  4'b0110, 4'b0001, 1'b0, 1'b1);
    push(XOR, 4'b0101, 4'b0001, 1'b0, 1'b1);
    push(AND, 4'b0100, 4'b0001, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    checks++;
    if (alu_a !== 4'b0111 || bus.out_valid !== 1'b0
        || acc !== 4'b1001) begin
      errors++;
      $display("FAIL mid_exec got a=%b v=%b acc=%b want 0111 0 1001",
               alu_a, bus.out_valid, acc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || acc !== 4'b0000
        || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b acc=%b rdy=%b busy=%b want 0 0 1 0",
               bus.out_valid, acc, bus.in_ready, busy);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale_%0d got v=%b busy=%b want 0 0",
                 i, bus.out_valid, busy);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_src_acc = 1'b0;
    bus.in_wr_acc  = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_add_latency();
    test_add_carry();
    test_chain();
    test_backpressure();
    test_stall_hold();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
